multiphase_clkgen: RTL and testbench

Synthesizable, parametrised successor to the team's behavioural two-phase clock generator. Produces NPHASE non-overlapping, one-hot phase enables from a single system clock, with runtime-programmable high and gap widths and start/stop control. Sits at the top of the datapath and drives the phi-qualified latches and registers in place of simulation-only `#delay` waveforms.

---
 rtl/multiphase_clkgen_pkg.sv | 11 +
 rtl/multiphase_clkgen_phase_timer.sv | 29 ++
 rtl/multiphase_clkgen.sv | 101 ++++++++++
 tb/tb_multiphase_clkgen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/multiphase_clkgen_pkg.sv
// Shared types and helpers for the multiphase clock generator.
package multiphase_clkgen_pkg;

  typedef enum logic [1:0] {IDLE, GAP, HIGH} state_e;

  // A programmed length of 0 behaves as 1 so every phase and gap lasts a cycle.
  function automatic int unsigned clamp_len(input int unsigned len);
    return (len == 0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/multiphase_clkgen_phase_timer.sv
// Loadable CW-bit down-counter that holds at zero; times GAP and HIGH intervals.
module phase_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] value_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/multiphase_clkgen.sv
// NPHASE non-overlapping one-hot phase enables with programmable high/gap widths.
module multiphase_clkgen
  import multiphase_clkgen_pkg::*;
#(
  parameter int NPHASE = 2,
  parameter int CW     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [CW-1:0]              hi_len,
  input  logic [CW-1:0]              gap_len,
  output logic [NPHASE-1:0]          phi,
  output logic [$clog2(NPHASE)-1:0]  phase_idx,
  output logic                       cycle_start,
  output logic                       busy
);

  localparam int PW = $clog2(NPHASE);

  state_e            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [NPHASE-1:0] phi_q, phi_d;
  logic              cs_q, cs_d, busy_q, busy_d;
  logic              ld;
  logic [CW-1:0]     ld_val, gap_m1, hi_m1;
  logic              cnt_zero;

  // Timer is loaded with length-1 so the interval spans exactly 'length' cycles.
  assign gap_m1 = CW'(clamp_len(32'(gap_len)) - 32'd1);
  assign hi_m1  = CW'(clamp_len(32'(hi_len)) - 32'd1);

  phase_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ld),
    .value_i (ld_val),
    .zero_o  (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ld      = 1'b0;
    ld_val  = gap_m1;
    case (state_q)
      IDLE: if (enable) begin
        state_d = GAP;
        ld      = 1'b1;
        ld_val  = gap_m1;
      end
      GAP: if (cnt_zero) begin
        state_d = HIGH;
        ld      = 1'b1;
        ld_val  = hi_m1;
      end
      HIGH: if (cnt_zero) begin
        phase_d = (phase_q == PW'(NPHASE - 1)) ? '0 : PW'(phase_q + 1'b1);
        if (enable) begin
          state_d = GAP;
          ld      = 1'b1;
          ld_val  = gap_m1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they register with it.
  always_comb begin
    phi_d = '0;
    for (int i = 0; i < NPHASE; i++)
      phi_d[i] = (state_d == HIGH) && (phase_d == PW'(i));
    cs_d   = (state_d == HIGH) && (state_q != HIGH) && (phase_d == '0);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      phi_q   <= '0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      phi_q   <= phi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
    end
  end

  assign phi         = phi_q;
  assign phase_idx   = phase_q;
  assign cycle_start = cs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_multiphase_clkgen.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
module tb_multiphase_clkgen;

  typedef struct packed {
    logic [3:0] phi;
    logic [1:0] idx;
    logic       cs;
    logic       busy;
  } rec_t;

  localparam int BIG = 1000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] hi_len = 8'd1;
  logic [7:0] gap_len = 8'd1;

  logic [1:0] phi2; logic [0:0] idx2; logic cs2, busy2;
  logic [2:0] phi3; logic [1:0] idx3; logic cs3, busy3;
  logic [3:0] phi4; logic [1:0] idx4; logic cs4, busy4;

  rec_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   sel = 4;
  bit   prop_en = 1'b0;
  logic [2:0] prev3 = '0;
  int   nxt3 = 0;

  always #5 clk = ~clk;

  multiphase_clkgen #(.NPHASE(2), .CW(8)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .hi_len(hi_len), .gap_len(gap_len),
    .phi(phi2), .phase_idx(idx2), .cycle_start(cs2), .busy(busy2));
  multiphase_clkgen #(.NPHASE(3), .CW(8)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .hi_len(hi_len), .gap_len(gap_len),
    .phi(phi3), .phase_idx(idx3), .cycle_start(cs3), .busy(busy3));
  multiphase_clkgen #(.NPHASE(4), .CW(8)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .hi_len(hi_len), .gap_len(gap_len),
    .phi(phi4), .phase_idx(idx4), .cycle_start(cs4), .busy(busy4));

  // Monitor: scoreboard compare every cycle plus the phase-order property on dut3.
  rec_t act, exp_r;
  int   c_inc, m_inc;
  logic bad;
  always @(negedge clk) begin
    c_inc = 0;
    m_inc = 0;
    case (sel)
      2:       act = '{phi: {2'b0, phi2}, idx: {1'b0, idx2}, cs: cs2, busy: busy2};
      3:       act = '{phi: {1'b0, phi3}, idx: idx3, cs: cs3, busy: busy3};
      default: act = '{phi: phi4, idx: idx4, cs: cs4, busy: busy4};
    endcase
    if (q.size() > 0) begin
      exp_r = q.pop_front();
      c_inc++;
      if (act !== exp_r) begin
        m_inc++;
        $display("FAIL scoreboard dut%0d t=%0t: got phi=%b idx=%0d cs=%b busy=%b, want phi=%b idx=%0d cs=%b busy=%b",
                 sel, $time, act.phi, act.idx, act.cs, act.busy,
                 exp_r.phi, exp_r.idx, exp_r.cs, exp_r.busy);
      end
    end
    if (prop_en) begin
      c_inc++;
      bad = !$onehot0(phi3) || (prev3 != 0 && phi3 != 0 && phi3 != prev3);
      if (bad) begin
        m_inc++;
        $display("FAIL onehot t=%0t: got phi=%b after %b, want one-hot-or-zero with gap", $time, phi3, prev3);
      end
      if (phi3 != 0 && prev3 == 0) begin
        c_inc++;
        if (phi3 != 3'(1 << nxt3)) begin
          m_inc++;
          $display("FAIL order t=%0t: got phi=%b, want phase %0d", $time, phi3, nxt3);
        end
        nxt3 <= (nxt3 + 1) % 3;
      end
    end else begin
      nxt3 <= 0;
    end
    prev3      <= phi3;
    compared   <= compared + c_inc;
    mismatched <= mismatched + m_inc;
  end

  function automatic rec_t mk(input logic [3:0] phi, input int idx, input logic cs, input logic busy);
    rec_t r;
    r.phi = phi; r.idx = 2'(idx); r.cs = cs; r.busy = busy;
    return r;
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected waveform for a run starting now from IDLE: current idle cycle, then n pulses of
  // g gap + h cycles high (first pulse h0), then idle. lhs = record index of last pulse's first high.
  task automatic exp_run(input int np, input int p0, input int g, input int h0, input int h,
                         input int n, input int lim, output int lhs);
    int k = 0;
    int p = p0;
    int hl;
    lhs = 0;
    if (k < lim) q.push_back(mk(4'b0, p, 1'b0, 1'b0));
    k++;
    for (int j = 0; j < n; j++) begin
      for (int t = 0; t < g; t++) begin
        if (k < lim) q.push_back(mk(4'b0, p, 1'b0, 1'b1));
        k++;
      end
      hl  = (j == 0) ? h0 : h;
      lhs = k;
      for (int t = 0; t < hl; t++) begin
        if (k < lim) q.push_back(mk(4'(1 << p), p, (t == 0 && p == 0), 1'b1));
        k++;
      end
      p = (p + 1) % np;
    end
    if (k < lim) q.push_back(mk(4'b0, p, 1'b0, 1'b0));
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      $display("FAIL drain: got %0d records pending, want 0", q.size());
      $fatal(1);
    end
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    wait_edges(1);
    q.push_back(mk(4'b0, 0, 1'b0, 1'b0));
    reset = 1'b0;
    wait_edges(1);
  endtask

  int lhs;

  initial begin
    // Basic two-phase run: period 10, cycle_start every 10 cycles.
    sel = 2; do_reset();
    hi_len = 8'd4; gap_len = 8'd1; enable = 1'b1;
    exp_run(2, 0, 1, 4, 4, 4, BIG, lhs);
    wait_edges(lhs); enable = 1'b0;
    drain();

    // Zero-length clamp: 1-cycle pulses separated by 1-cycle gaps.
    sel = 2; do_reset();
    hi_len = 8'd0; gap_len = 8'd0; enable = 1'b1;
    exp_run(2, 0, 1, 1, 1, 6, BIG, lhs);
    wait_edges(lhs); enable = 1'b0;
    drain();

    // Stop during 3rd cycle of phi[2], then restart at phi[3].
    sel = 4; do_reset();
    hi_len = 8'd6; gap_len = 8'd2; enable = 1'b1;
    exp_run(4, 0, 2, 6, 6, 3, BIG, lhs);
    wait_edges(lhs + 2); enable = 1'b0;
    drain();
    wait_edges(3);
    enable = 1'b1;
    exp_run(4, 3, 2, 6, 6, 2, BIG, lhs);
    wait_edges(lhs); enable = 1'b0;
    drain();

    // Reset in the middle of phi[1]; restart begins at phi[0].
    sel = 4; do_reset();
    hi_len = 8'd6; gap_len = 8'd2; enable = 1'b1;
    exp_run(4, 0, 2, 6, 6, 2, 14, lhs);
    wait_edges(13); reset = 1'b1;
    wait_edges(1);  reset = 1'b0;
    exp_run(4, 0, 2, 6, 6, 2, BIG, lhs);
    wait_edges(lhs); enable = 1'b0;
    drain();

    // hi_len 3 -> 5 during the first pulse: first pulse 3, later pulses 5.
    sel = 4; do_reset();
    hi_len = 8'd3; gap_len = 8'd1; enable = 1'b1;
    exp_run(4, 0, 1, 3, 5, 3, BIG, lhs);
    wait_edges(2); hi_len = 8'd5;
    wait_edges(lhs - 2); enable = 1'b0;
    drain();

    // Maximum lengths: 255 gap cycles and 255 high cycles.
    sel = 2; do_reset();
    hi_len = 8'd255; gap_len = 8'd255; enable = 1'b1;
    exp_run(2, 0, 255, 255, 255, 1, BIG, lhs);
    wait_edges(lhs); enable = 1'b0;
    drain();

    // Random lengths on three phases: one-hot-or-zero and strict 0,1,2 order.
    sel = 3; do_reset();
    hi_len = 8'($urandom_range(0, 4)); gap_len = 8'($urandom_range(0, 4));
    enable = 1'b1; prop_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      wait_edges(1);
      hi_len  = 8'($urandom_range(0, 4));
      gap_len = 8'($urandom_range(0, 4));
    end
    enable = 1'b0;
    wait_edges(20);
    prop_en = 1'b0;
    drain();

    wait_edges(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
